// File: rtl/dma_timing_ctrl_gen.sv
// Fixed-priority DMA arbiter with HRQ/HLDA handshake and SI/S0/S1/S2/S3/SW/S4 bus timing.
// Optional feature: define DMA_COMPRESSED_TIMING_EN to enable compressed (S3-less) timing.
module dma_timing_ctrl_gen #(
  parameter int NCH      = 4,
  parameter int MAX_WAIT = 15,
  localparam int CHW     = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [NCH-1:0]   dreq,
  input  logic             hlda,
  input  logic             ready,
  input  logic             eop_n_in,
  input  logic [NCH-1:0]   tc,
  input  logic [2*NCH-1:0] xfer_type,
  input  logic [2*NCH-1:0] xfer_mode,
  input  logic             cmd_disable,
  input  logic             cmd_ext_wr,
  input  logic             cmd_compress,
  input  logic             addr_carry,
  output logic             hrq,
  output logic             aen,
  output logic             adstb,
  output logic [NCH-1:0]   dack,
  output logic             ior_n,
  output logic             iow_n,
  output logic             memr_n,
  output logic             memw_n,
  output logic             strobe_oe,
  output logic             eop_n_out,
  output logic             ld_cnt,
  output logic [CHW-1:0]   active_ch,
  output logic             wd_timeout
);

  typedef enum logic [2:0] {
    ST_SI, ST_S0, ST_S1, ST_S2, ST_S3, ST_SW, ST_S4
  } state_e;

  localparam logic [1:0] TYPE_WRITE  = 2'b01;
  localparam logic [1:0] TYPE_READ   = 2'b10;
  localparam logic [1:0] MODE_DEMAND = 2'b00;
  localparam logic [1:0] MODE_BLOCK  = 2'b10;
  localparam logic [7:0] WD_LIMIT    = 8'(MAX_WAIT - 1);

  state_e         state, nextState;
  logic [CHW-1:0] activeCh, reqIdx;
  logic [1:0]     chType, chMode, reqType, reqMode;
  logic           eopLatched, wdFlag;
  logic [7:0]     waitCnt;
  logic           chReq, tcCur, inCycle, wdHit, terminate, contNext;
  logic           readOn, writeOn;
  logic           compressOn, carryNext;

`ifdef DMA_COMPRESSED_TIMING_EN
  assign compressOn = cmd_compress;
  assign carryNext  = addr_carry;
`else
  logic unusedCfg;
  assign compressOn = 1'b0;
  assign carryNext  = 1'b1;
  assign unusedCfg  = cmd_compress ^ addr_carry;
`endif

  // Lowest-numbered active request wins; its type/mode are captured on grant.
  always_comb begin
    reqIdx  = '0;
    reqType = '0;
    reqMode = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (dreq[i]) begin
        reqIdx  = CHW'(i);
        reqType = xfer_type[2*i +: 2];
        reqMode = xfer_mode[2*i +: 2];
      end
    end
  end

  assign chReq     = dreq[activeCh];
  assign tcCur     = tc[activeCh];
  assign inCycle   = (state == ST_S1) || (state == ST_S2) || (state == ST_S3) || (state == ST_SW);
  assign wdHit     = (state == ST_SW) && hlda && !ready && (waitCnt == WD_LIMIT);
  assign terminate = tcCur || eopLatched || wdFlag;
  assign contNext  = (chMode == MODE_BLOCK) || ((chMode == MODE_DEMAND) && chReq);

  always_comb begin
    nextState = state;
    case (state)
      ST_SI: if (|dreq && !cmd_disable) nextState = ST_S0;
      ST_S0: begin
        if (hlda)        nextState = ST_S1;
        else if (!chReq) nextState = ST_SI;
      end
      ST_S1: nextState = hlda ? ST_S2 : ST_SI;
      ST_S2: begin
        if (!hlda)           nextState = ST_SI;
        else if (compressOn) nextState = ready ? ST_S4 : ST_SW;
        else                 nextState = ST_S3;
      end
      ST_S3: begin
        if (!hlda)      nextState = ST_SI;
        else if (ready) nextState = ST_S4;
        else            nextState = ST_SW;
      end
      ST_SW: begin
        if (!hlda)               nextState = ST_SI;
        else if (ready || wdHit) nextState = ST_S4;
      end
      ST_S4: begin
        if (terminate || !hlda || !contNext) nextState = ST_SI;
        else if (compressOn && !carryNext)   nextState = ST_S2;
        else                                 nextState = ST_S1;
      end
      default: nextState = ST_SI;
    endcase
  end

  // Watchdog flag is sticky across the return to SI and only clears on the next grant.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state      <= ST_SI;
      activeCh   <= '0;
      chType     <= '0;
      chMode     <= '0;
      eopLatched <= 1'b0;
      wdFlag     <= 1'b0;
      waitCnt    <= '0;
    end else begin
      state <= nextState;
      if ((state == ST_SI) && (nextState == ST_S0)) begin
        activeCh <= reqIdx;
        chType   <= reqType;
        chMode   <= reqMode;
        wdFlag   <= 1'b0;
      end else if (wdHit) begin
        wdFlag <= 1'b1;
      end
      if (state == ST_SI)
        eopLatched <= 1'b0;
      else if (inCycle && !eop_n_in)
        eopLatched <= 1'b1;
      waitCnt <= (state == ST_SW) ? waitCnt + 8'd1 : 8'd0;
    end
  end

  // Bus outputs are decoded from state plus the latched channel/type.
  always_comb begin
    hrq       = 1'b0;
    aen       = 1'b0;
    adstb     = 1'b0;
    dack      = '0;
    ld_cnt    = 1'b0;
    eop_n_out = 1'b1;
    readOn    = 1'b0;
    writeOn   = 1'b0;
    case (state)
      ST_S0: hrq = 1'b1;
      ST_S1: begin
        hrq   = 1'b1;
        aen   = 1'b1;
        adstb = 1'b1;
      end
      ST_S2: begin
        hrq     = 1'b1;
        aen     = 1'b1;
        readOn  = 1'b1;
        writeOn = cmd_ext_wr || compressOn;
      end
      ST_S3, ST_SW: begin
        hrq     = 1'b1;
        aen     = 1'b1;
        readOn  = 1'b1;
        writeOn = 1'b1;
      end
      ST_S4: begin
        hrq       = 1'b1;
        aen       = 1'b1;
        ld_cnt    = 1'b1;
        eop_n_out = !tcCur;
      end
      default: ;
    endcase
    if (aen) dack[activeCh] = 1'b1;
  end

  // Verify (and the reserved type) never drives a strobe.
  assign ior_n  = !((chType == TYPE_WRITE) && readOn);
  assign memw_n = !((chType == TYPE_WRITE) && writeOn);
  assign memr_n = !((chType == TYPE_READ) && readOn);
  assign iow_n  = !((chType == TYPE_READ) && writeOn);

  assign strobe_oe  = hlda;
  assign active_ch  = activeCh;
  assign wd_timeout = wdFlag;

endmodule

// File: tb/tb_dma_timing_ctrl_gen.sv
// Self-checking bench for dma_timing_ctrl_gen (default build, NCH=4, MAX_WAIT=15).
// Scenarios expand into an expected per-cycle bus trace that is compared every cycle.
module tb_dma_timing_ctrl_gen;

  localparam int NCH      = 4;
  localparam int MAX_WAIT = 15;

  logic           CLK;
  logic           RESET;
  logic [3:0]     dreq, tc, dack;
  logic           hlda, ready, eop_n_in;
  logic [7:0]     xfer_type, xfer_mode;
  logic           cmd_disable, cmd_ext_wr, cmd_compress, addr_carry;
  logic           hrq, aen, adstb, ior_n, iow_n, memr_n, memw_n;
  logic           strobe_oe, eop_n_out, ld_cnt, wd_timeout;
  logic [1:0]     active_ch;

  dma_timing_ctrl_gen #(.NCH(NCH), .MAX_WAIT(MAX_WAIT)) dut (
    .CLK(CLK), .RESET(RESET), .dreq(dreq), .hlda(hlda), .ready(ready),
    .eop_n_in(eop_n_in), .tc(tc), .xfer_type(xfer_type), .xfer_mode(xfer_mode),
    .cmd_disable(cmd_disable), .cmd_ext_wr(cmd_ext_wr), .cmd_compress(cmd_compress),
    .addr_carry(addr_carry), .hrq(hrq), .aen(aen), .adstb(adstb), .dack(dack),
    .ior_n(ior_n), .iow_n(iow_n), .memr_n(memr_n), .memw_n(memw_n),
    .strobe_oe(strobe_oe), .eop_n_out(eop_n_out), .ld_cnt(ld_cnt),
    .active_ch(active_ch), .wd_timeout(wd_timeout)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef enum {P_SI, P_S0, P_S1, P_S2, P_S3, P_SW, P_S4} phase_e;

  typedef struct packed {
    logic       hrq, aen, adstb;
    logic [3:0] dack;
    logic       ior_n, iow_n, memr_n, memw_n, strobe_oe, eop_n_out, ld_cnt;
    logic [1:0] active_ch;
    logic       wd_timeout;
  } outv_t;

  typedef struct {
    phase_e     ph;
    logic [3:0] dreq;
    logic       hlda, ready, eopN, tcCh;
    outv_t      exp;
  } cycle_t;

  typedef struct {
    logic [3:0] dreq, lateReq;
    logic [1:0] typ, mode;
    int         hldaDelay, wait0, tcAt, eopAt, demandStop, hldaDropAt;
    bit         s0Abandon, extWr;
    int         expLd, expCh;
  } scen_t;

  int         testsRun = 0;
  int         failures = 0;
  cycle_t     cycQ[$];
  int         curCh;
  bit         wdSticky, curExt;
  logic [1:0] curTyp;

  // Spec-level view of what the pins show in each named bus state.
  function automatic outv_t expOut(phase_e p, logic hl, logic tcIn);
    outv_t o;
    bit busy, rdOn, wrOn, isWr, isRd;
    busy        = p inside {P_S1, P_S2, P_S3, P_SW, P_S4};
    rdOn        = p inside {P_S2, P_S3, P_SW};
    wrOn        = (p inside {P_S3, P_SW}) || (p == P_S2 && curExt);
    isWr        = (curTyp == 2'b01);
    isRd        = (curTyp == 2'b10);
    o.hrq       = (p != P_SI);
    o.aen       = busy;
    o.adstb     = (p == P_S1);
    o.dack      = busy ? 4'(1 << curCh) : 4'b0000;
    o.ior_n     = !(isWr && rdOn);
    o.memw_n    = !(isWr && wrOn);
    o.memr_n    = !(isRd && rdOn);
    o.iow_n     = !(isRd && wrOn);
    o.strobe_oe = hl;
    o.eop_n_out = !(p == P_S4 && tcIn);
    o.ld_cnt    = (p == P_S4);
    o.active_ch = 2'(curCh);
    o.wd_timeout = wdSticky;
    return o;
  endfunction

  task automatic pushCycle(input phase_e p, input logic [3:0] rq, input logic hl,
                           input logic rdy, input logic eopN, input logic tcIn);
    cycle_t c;
    c.ph = p; c.dreq = rq; c.hlda = hl; c.ready = rdy; c.eopN = eopN; c.tcCh = tcIn;
    c.exp = expOut(p, hl, tcIn);
    cycQ.push_back(c);
  endtask

  // Expands a transaction description into the cycle sequence the bus should follow.
  task automatic buildScenario(input scen_t s, output int ldExp, output int chExp);
    logic [3:0] rq;
    int  ch, w;
    bit  done, eopSeen, abort, tcHere;
    cycQ.delete();
    ldExp = 0;
    ch = 0;
    for (int i = NCH - 1; i >= 0; i--) if (s.dreq[i]) ch = i;
    chExp = ch;
    rq = s.dreq;
    curTyp = s.typ;
    curExt = s.extWr;
    pushCycle(P_SI, rq, 1'b0, 1'b1, 1'b1, 1'b0);
    curCh = ch;
    wdSticky = 1'b0;
    if (s.s0Abandon) begin
      pushCycle(P_S0, rq, 1'b0, 1'b1, 1'b1, 1'b0);
      rq[ch] = 1'b0;
      pushCycle(P_S0, rq, 1'b0, 1'b1, 1'b1, 1'b0);
    end else begin
      for (int d = 0; d < s.hldaDelay; d++) pushCycle(P_S0, rq, 1'b0, 1'b1, 1'b1, 1'b0);
      pushCycle(P_S0, rq, 1'b1, 1'b1, 1'b1, 1'b0);
      done = 1'b0;
      eopSeen = 1'b0;
      for (int j = 0; j < 8 && !done; j++) begin
        pushCycle(P_S1, rq, 1'b1, 1'b1, 1'b1, 1'b0);
        if (j == s.hldaDropAt) begin
          pushCycle(P_S2, rq, 1'b0, 1'b1, 1'b1, 1'b0);
          done = 1'b1;
        end else begin
          if (j == s.eopAt) eopSeen = 1'b1;
          pushCycle(P_S2, rq, 1'b1, 1'b1, (j == s.eopAt) ? 1'b0 : 1'b1, 1'b0);
          w = (j == 0) ? s.wait0 : 0;
          abort = (w > MAX_WAIT);
          pushCycle(P_S3, rq, 1'b1, (w == 0), 1'b1, 1'b0);
          for (int k = 1; k <= w && k <= MAX_WAIT; k++)
            pushCycle(P_SW, rq, 1'b1, (k == w), 1'b1, 1'b0);
          if (abort) wdSticky = 1'b1;
          tcHere = (j == s.tcAt);
          if (j == s.demandStop) rq[ch] = 1'b0;
          pushCycle(P_S4, rq, 1'b1, 1'b1, 1'b1, tcHere);
          ldExp++;
          if (tcHere || eopSeen || abort) done = 1'b1;
          else if (s.mode == 2'b10)       done = 1'b0;
          else if (s.mode == 2'b00)       done = !rq[ch];
          else                            done = 1'b1;
          if (j == 0) rq |= s.lateReq;
        end
      end
    end
    pushCycle(P_SI, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic checkOutput(input outv_t exp, input string tag);
    outv_t act;
    act = {hrq, aen, adstb, dack, ior_n, iow_n, memr_n, memw_n, strobe_oe,
           eop_n_out, ld_cnt, active_ch, wd_timeout};
    testsRun++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %b required %b", tag, act, exp);
    end
  endtask

  task automatic checkInt(input string tag, input int act, input int req);
    testsRun++;
    if (act != req) begin
      failures++;
      $display("[TB] FAIL %s: got %0d required %0d", tag, act, req);
    end
  endtask

  // Drives one queued cycle per clock just after the edge and checks on the falling edge.
  task automatic applyStimulus(input int id, input int limit, output int ldSeen,
                               output logic [1:0] lastCh);
    ldSeen = 0;
    lastCh = active_ch;
    for (int n = 0; n < cycQ.size() && n < limit; n++) begin
      @(posedge CLK);
      #1;
      dreq     = cycQ[n].dreq;
      hlda     = cycQ[n].hlda;
      ready    = cycQ[n].ready;
      eop_n_in = cycQ[n].eopN;
      tc       = 4'($urandom_range(0, 15));
      tc[cycQ[n].exp.active_ch] = cycQ[n].tcCh;
      cmd_compress = 1'($urandom_range(0, 1));
      addr_carry   = 1'($urandom_range(0, 1));
      @(negedge CLK);
      checkOutput(cycQ[n].exp, $sformatf("s%0d c%0d %s", id, n, cycQ[n].ph.name()));
      if (ld_cnt) ldSeen++;
      lastCh = active_ch;
    end
  endtask

  task automatic runScenario(input scen_t s, input int id);
    int ldExp, chExp, ldSeen;
    logic [1:0] lastCh;
    buildScenario(s, ldExp, chExp);
    for (int i = 0; i < NCH; i++) begin
      xfer_type[2*i +: 2] = 2'($urandom_range(0, 3));
      xfer_mode[2*i +: 2] = 2'($urandom_range(0, 3));
    end
    xfer_type[2*chExp +: 2] = s.typ;
    xfer_mode[2*chExp +: 2] = s.mode;
    cmd_ext_wr = s.extWr;
    applyStimulus(id, cycQ.size(), ldSeen, lastCh);
    checkInt($sformatf("s%0d ld_cnt pulses", id), ldSeen, (s.expLd >= 0) ? s.expLd : ldExp);
    checkInt($sformatf("s%0d granted channel", id), int'(lastCh), (s.expCh >= 0) ? s.expCh : chExp);
  endtask

  function automatic scen_t mk(logic [3:0] rq, logic [3:0] late, logic [1:0] typ, logic [1:0] mode,
                               int hd, int w0, int tcAt, int eopAt, int dStop, int hDrop,
                               bit ab, bit ext, int expLd, int expCh);
    scen_t s;
    s.dreq = rq; s.lateReq = late; s.typ = typ; s.mode = mode; s.hldaDelay = hd;
    s.wait0 = w0; s.tcAt = tcAt; s.eopAt = eopAt; s.demandStop = dStop;
    s.hldaDropAt = hDrop; s.s0Abandon = ab; s.extWr = ext; s.expLd = expLd; s.expCh = expCh;
    return s;
  endfunction

  scen_t tbl[12];

  initial begin
    scen_t s;
    int    ldDummy;
    logic [1:0] chDummy;

    // typ: 01 write, 10 read, 00 verify; mode: 00 demand, 01 single, 10 block
    tbl[0]  = mk(4'b0110, 4'b0000, 2'b01, 2'b01, 2,  0, -1, -1, -1, -1, 0, 0, 1, 1);
    tbl[1]  = mk(4'b0001, 4'b0000, 2'b10, 2'b10, 1,  0,  2, -1, -1, -1, 0, 0, 3, 0);
    tbl[2]  = mk(4'b0100, 4'b0000, 2'b10, 2'b01, 0,  5, -1, -1, -1, -1, 0, 0, 1, 2);
    tbl[3]  = mk(4'b1000, 4'b0000, 2'b01, 2'b01, 1, 20, -1, -1, -1, -1, 0, 0, 1, 3);
    tbl[4]  = mk(4'b0010, 4'b0000, 2'b10, 2'b00, 0,  0, -1, -1,  1, -1, 0, 0, 2, 1);
    tbl[5]  = mk(4'b0001, 4'b0000, 2'b01, 2'b00, 0,  0, -1, -1, -1,  0, 0, 0, 0, 0);
    tbl[6]  = mk(4'b1000, 4'b0000, 2'b10, 2'b10, 0,  0, -1,  1, -1, -1, 0, 0, 2, 3);
    tbl[7]  = mk(4'b0010, 4'b0000, 2'b01, 2'b01, 3,  0, -1, -1, -1, -1, 1, 0, 0, 1);
    tbl[8]  = mk(4'b0001, 4'b0000, 2'b01, 2'b10, 0,  0,  0,  0, -1, -1, 0, 0, 1, 0);
    tbl[9]  = mk(4'b0100, 4'b0001, 2'b10, 2'b10, 0,  2,  2, -1, -1, -1, 0, 0, 3, 2);
    tbl[10] = mk(4'b1000, 4'b0000, 2'b01, 2'b01, 0,  0, -1, -1, -1, -1, 0, 1, 1, 3);
    tbl[11] = mk(4'b0010, 4'b0000, 2'b00, 2'b00, 1,  1,  1, -1, -1, -1, 0, 0, 2, 1);

    RESET = 1'b1;
    dreq = '0; hlda = 1'b0; ready = 1'b1; eop_n_in = 1'b1; tc = '0;
    xfer_type = '0; xfer_mode = '0; cmd_disable = 1'b0; cmd_ext_wr = 1'b0;
    cmd_compress = 1'b0; addr_carry = 1'b0;
    curCh = 0; wdSticky = 1'b0; curTyp = 2'b00; curExt = 1'b0;
    #12;
    checkOutput(expOut(P_SI, 1'b0, 1'b0), "reset state");
    @(negedge CLK);
    RESET = 1'b0;

    for (int t = 0; t < 12; t++) runScenario(tbl[t], t);

    // Disabled controller must ignore pending requests.
    cmd_disable = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge CLK);
      #1;
      dreq = 4'b1000;
      @(negedge CLK);
      checkOutput(expOut(P_SI, 1'b0, 1'b0), $sformatf("cmd_disable c%0d", c));
    end
    @(posedge CLK);
    #1;
    dreq = 4'b0000;
    cmd_disable = 1'b0;

    // Asynchronous reset while parked in wait states.
    s = mk(4'b0100, 4'b0000, 2'b10, 2'b10, 0, 20, -1, -1, -1, -1, 0, 0, -1, -1);
    buildScenario(s, ldDummy, ldDummy);
    xfer_type[5:4] = 2'b10;
    xfer_mode[5:4] = 2'b10;
    applyStimulus(50, 9, ldDummy, chDummy);
    #2;
    RESET = 1'b1;
    dreq = 4'b0000;
    hlda = 1'b0;
    ready = 1'b1;
    #1;
    curCh = 0;
    wdSticky = 1'b0;
    checkOutput(expOut(P_SI, 1'b0, 1'b0), "async reset mid-SW");
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    checkOutput(expOut(P_SI, 1'b0, 1'b0), "idle after reset release");

    for (int r = 0; r < 40; r++) begin
      s.dreq       = 4'($urandom_range(1, 15));
      s.lateReq    = 4'($urandom_range(0, 15));
      s.typ        = 2'($urandom_range(0, 2));
      s.mode       = 2'($urandom_range(0, 2));
      s.hldaDelay  = int'($urandom_range(0, 3));
      s.wait0      = ($urandom_range(0, 7) == 0) ? 20 : int'($urandom_range(0, 4));
      if (s.mode == 2'b01) s.tcAt = ($urandom_range(0, 1) == 1) ? 0 : -1;
      else                 s.tcAt = int'($urandom_range(0, 3));
      s.eopAt      = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1;
      s.demandStop = (s.mode == 2'b00 && $urandom_range(0, 1) == 1) ? int'($urandom_range(0, 3)) : -1;
      s.hldaDropAt = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 2)) : -1;
      s.s0Abandon  = ($urandom_range(0, 9) == 0);
      s.extWr      = 1'($urandom_range(0, 1));
      s.expLd      = -1;
      s.expCh      = -1;
      runScenario(s, 100 + r);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failures);
    $finish;
  end

endmodule
